// File: rtl/sbox_gf2p8_pipe.sv
// AES S-box / inverse S-box over GF(((2^2)^2)^2), 4-stage valid/ready pipeline, 4-cycle latency, 1 byte/cycle.
// Each stage advances when empty or when the stage after it advances, so bubbles collapse under output stall.
module sbox_gf2p8_pipe #(
    parameter int ENABLE_INV = 1,
    parameter int STAGES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    input  logic       in_inv,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       busy
);

    generate
        if (STAGES != 4) begin : g_bad_stages
            $error("sbox_gf2p8_pipe: STAGES must be 4");
        end
    endgenerate

    // GF(2^2): poly basis {W,1}, W^2 = W + 1
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]), (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    function automatic logic [1:0] gf4_mul_phi(input logic [1:0] a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    // GF(2^4) over GF(2^2): Y^2 = Y + phi, phi = W
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh;
        hh = gf4_mul(a[3:2], b[3:2]);
        return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
                gf4_mul_phi(hh) ^ gf4_mul(a[1:0], b[1:0])};
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [1:0] d;
        logic [1:0] di;
        d  = gf4_mul_phi(gf4_sq(a[3:2])) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]);
        di = gf4_sq(d);
        return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
    endfunction

    // GF(2^8) over GF(2^4): Z^2 = Z + lambda
    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b, input logic [3:0] lam);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(lam, hh) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    // Smallest lambda with no root of z^2 + z + lambda in GF(2^4)
    function automatic logic [3:0] find_lambda();
        logic [3:0] r;
        logic [3:0] z4;
        logic [3:0] l4;
        logic       hit;
        r = 4'h0;
        for (int l = 15; l >= 1; l--) begin
            l4  = l[3:0];
            hit = 1'b0;
            for (int z = 0; z < 16; z++) begin
                z4 = z[3:0];
                if ((gf16_mul(z4, z4) ^ z4) == l4) hit = 1'b1;
            end
            if (!hit) r = l4;
        end
        return r;
    endfunction

    function automatic logic [7:0] lin_map(input logic [63:0] cols, input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) r = r ^ cols[i*8 +: 8];
        end
        return r;
    endfunction

    // Isomorphism columns: AES x^i -> beta^i, beta a tower root of x^8+x^4+x^3+x+1
    function automatic logic [63:0] build_map(input logic [3:0] lam);
        logic [63:0] cols;
        logic [7:0]  b;
        logic [7:0]  p;
        logic [7:0]  acc;
        logic        found;
        cols  = '0;
        found = 1'b0;
        for (int c = 2; c < 256; c++) begin
            if (!found) begin
                b   = c[7:0];
                p   = 8'h01;
                acc = 8'h00;
                for (int i = 0; i <= 8; i++) begin
                    if (i == 0 || i == 1 || i == 3 || i == 4 || i == 8) acc = acc ^ p;
                    if (i < 8) cols[i*8 +: 8] = p;
                    p = gf256_mul(p, b, lam);
                end
                if (acc == 8'h00) found = 1'b1;
            end
        end
        return cols;
    endfunction

    function automatic logic [63:0] build_unmap(input logic [63:0] cols);
        logic [63:0] ucols;
        logic [7:0]  e;
        logic [7:0]  a8;
        ucols = '0;
        for (int j = 0; j < 8; j++) begin
            e = 8'h01 << j;
            for (int a = 1; a < 256; a++) begin
                a8 = a[7:0];
                if (lin_map(cols, a8) == e) ucols[j*8 +: 8] = a8;
            end
        end
        return ucols;
    endfunction

    localparam logic [3:0]  LAMBDA = find_lambda();
    localparam logic [63:0] MAP    = build_map(LAMBDA);
    localparam logic [63:0] UNMAP  = build_unmap(MAP);

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    logic       v1, v2, v3, v4;
    logic       m1, m2, m3;
    logic [3:0] ah1, al1, d2, ah2, al2, di3, ah3, al3;
    logic [7:0] out_q;
    logic       adv2, adv3, adv4;
    logic       mode_in;
    logic [7:0] s1_map, s4_raw, s4_res;
    logic [3:0] s2_d, s3_di;

    assign adv4     = !v4 || out_ready;
    assign adv3     = !v3 || adv4;
    assign adv2     = !v2 || adv3;
    assign in_ready = !v1 || adv2;

    assign mode_in = (ENABLE_INV != 0) ? in_inv : 1'b0;
    assign s1_map  = lin_map(MAP, mode_in ? inv_affine(in_byte) : in_byte);
    assign s2_d    = gf16_mul(LAMBDA, gf16_mul(ah1, ah1)) ^ gf16_mul(ah1 ^ al1, al1);
    assign s3_di   = gf16_inv(d2);
    assign s4_raw  = lin_map(UNMAP, {gf16_mul(ah3, di3), gf16_mul(ah3 ^ al3, di3)});
    assign s4_res  = m3 ? s4_raw : fwd_affine(s4_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, v3, v4} <= 4'b0000;
            {m1, m2, m3}     <= 3'b000;
            {ah1, al1, d2, ah2, al2, di3, ah3, al3} <= '0;
            out_q <= 8'h00;
        end else begin
            if (in_ready) begin
                v1 <= in_valid;
                if (in_valid) begin
                    m1         <= mode_in;
                    {ah1, al1} <= s1_map;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    m2  <= m1;
                    d2  <= s2_d;
                    ah2 <= ah1;
                    al2 <= al1;
                end
            end
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    m3  <= m2;
                    di3 <= s3_di;
                    ah3 <= ah2;
                    al3 <= al2;
                end
            end
            if (adv4) begin
                v4 <= v3;
                if (v3) out_q <= s4_res;
            end
        end
    end

    assign out_valid = v4;
    assign out_byte  = out_q;
    assign busy      = v1 | v2 | v3 | v4;

endmodule

// File: tb/tb_sbox_gf2p8_pipe.sv
// Directed bench for sbox_gf2p8_pipe: S-box/InvS-box vectors, streaming, backpressure, bubbles, reset.
module tb_sbox_gf2p8_pipe;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [7:0] in_byte, out_byte;

    always #5 clk = ~clk;

    sbox_gf2p8_pipe #(.ENABLE_INV(1), .STAGES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .busy(busy)
    );

    typedef struct {
        logic [7:0] exp;
        int         cyc;
    } ent_t;

    ent_t       q[$];
    logic [7:0] sbox_tbl [256];
    logic [7:0] inv_tbl  [256];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         chk_lat = 1'b0;
    bit         chk_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One bench cycle: drive on the falling edge, sample 1ns later, score transfers.
    task automatic step(input logic r, input logic iv, input logic [7:0] ib, input logic ii,
                        input logic [7:0] ie, input logic ordy, output logic acc);
        ent_t e;
        int   occ;
        @(negedge clk);
        rst = r; in_valid = iv; in_byte = ib; in_inv = ii; out_ready = ordy;
        #1;
        occ = q.size();
        acc = !r && iv && in_ready;
        if (chk_rdy) begin
            chk("in_ready", {31'b0, in_ready}, (occ == 4 && !ordy) ? 32'd0 : 32'd1);
            chk("busy", {31'b0, busy}, {31'b0, occ != 0});
        end
        if (!r && out_valid) begin
            if (q.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'd0);
            else if (ordy) begin
                e = q.pop_front();
                chk("out_byte", {24'b0, out_byte}, {24'b0, e.exp});
                if (chk_lat) chk("latency", cyc - e.cyc, 32'd4);
            end else chk("stall_hold", {24'b0, out_byte}, {24'b0, q[0].exp});
        end
        if (acc) begin
            e.exp = ie;
            e.cyc = cyc;
            q.push_back(e);
        end
        if (r) q.delete();
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
    endtask

    logic [7:0] vin  [4];
    logic [7:0] vout [4];
    logic       a;
    logic [7:0] bb;
    int         nb;

    initial begin
        sbox_tbl = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
        for (int k = 0; k < 256; k++) inv_tbl[sbox_tbl[k]] = k[7:0];

        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; in_inv = 1'b0; out_ready = 1'b1;

        // Reset with in_valid high: nothing may enter.
        step(1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, a);
        step(1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1, a);
        chk_rdy = 1'b1;
        idle(1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_byte", {24'b0, out_byte}, 32'h00);
        idle(5);

        // Single forward bytes, 4-cycle latency each.
        chk_lat = 1'b1;
        vin  = '{8'h00, 8'h01, 8'h53, 8'hFF};
        vout = '{8'h63, 8'h7C, 8'hED, 8'h16};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, vin[k], 1'b0, vout[k], 1'b1, a);
            chk("fwd_accept", {31'b0, a}, 32'd1);
            idle(5);
        end

        // Single inverse bytes.
        vin  = '{8'h63, 8'hED, 8'h7C, 8'h16};
        vout = '{8'h00, 8'h53, 8'h01, 8'hFF};
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, vin[k], 1'b1, vout[k], 1'b1, a);
            chk("inv_accept", {31'b0, a}, 32'd1);
            idle(5);
        end

        // All 256 values back-to-back, alternating direction.
        chk_rdy = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bb = i[7:0];
            step(1'b0, 1'b1, bb, bb[0], bb[0] ? inv_tbl[bb] : sbox_tbl[bb], 1'b1, a);
            chk("stream_accept", {31'b0, a}, 32'd1);
        end
        idle(6);
        chk("stream_drained", q.size(), 32'd0);

        // Backpressure: 0x00..0x09 with a 6-cycle output stall while byte 0 is presented.
        chk_lat = 1'b0;
        chk_rdy = 1'b1;
        nb = 0;
        for (int t = 0; t < 30; t++) begin
            bb = nb[7:0];
            step(1'b0, nb < 10, bb, 1'b0, sbox_tbl[bb], !(t >= 4 && t < 10), a);
            if (t >= 4 && t < 10) chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            if (a) nb++;
        end
        chk("bp_all_accepted", nb, 32'd10);
        chk("bp_drained", q.size(), 32'd0);

        // Bubble collapse: one byte stalls at the output, later bytes still fill the pipe.
        nb = 0;
        for (int t = 0; t < 24; t++) begin
            bb = 8'((nb + 1) * 16);
            step(1'b0, (t == 0 || t >= 3) && nb < 5, bb, 1'b0, sbox_tbl[bb], t >= 9, a);
            if (t == 3) chk("bubble_second_accept", {31'b0, a}, 32'd1);
            if (a) nb++;
        end
        chk("bubble_all_accepted", nb, 32'd5);
        chk("bubble_drained", q.size(), 32'd0);

        // Reset with three bytes in flight.
        chk_rdy = 1'b0;
        chk_lat = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bb = 8'hA0 + k[7:0];
            step(1'b0, 1'b1, bb, 1'b0, sbox_tbl[bb], 1'b1, a);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, a);
        idle(1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        idle(6);
        step(1'b0, 1'b1, 8'h53, 1'b0, 8'hED, 1'b1, a);
        chk("midrst_accept", {31'b0, a}, 32'd1);
        idle(6);
        chk("midrst_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
